// File: rtl/program_loader.sv
// Streams a program image (count, big-endian 16-bit words, XOR checksum) into the
// CPU RAM from address 0 and releases the CPU hold only after a verified load.
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR} state_t;

  state_t                state;
  logic [7:0]            n;
  logic [7:0]            hi;
  logic [7:0]            sum;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  take;

  // in_ready is registered and only high in the byte-receiving states.
  assign take = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mem_write  <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      cpu_hold   <= 1'b1;
      addr       <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= COUNT;
            in_ready   <= 1'b1;
            addr       <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            sum        <= '0;
          end
        end
        COUNT: begin
          if (take) begin
            n   <= in_byte;
            sum <= sum ^ in_byte;
            if (in_byte == 8'd0) begin
              state <= CHECK;
            end else if (32'(in_byte) > DEPTH) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= HI;
            end
          end
        end
        HI: begin
          if (take) begin
            hi    <= in_byte;
            sum   <= sum ^ in_byte;
            state <= LO;
          end
        end
        LO: begin
          if (take) begin
            mem_wdata <= DATA_WIDTH'({hi, in_byte});
            mem_waddr <= addr;
            sum       <= sum ^ in_byte;
            mem_write <= 1'b1;
            in_ready  <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_WIDTH'(1);
          word_count <= word_count + CW'(1);
          in_ready   <= 1'b1;
          if (32'(word_count) + 32'd1 == 32'(n)) begin
            state <= CHECK;
          end else begin
            state <= HI;
          end
        end
        CHECK: begin
          if (take) begin
            in_ready <= 1'b0;
            if (in_byte == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives bytes on the falling edge, records
// RAM writes on the falling edge, and checks against hand-computed results.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic [7:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic       mem_write;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [8:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;
  int base;
  logic [7:0]  wa[$];
  logic [15:0] wd[$];

  program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .cpu_hold(cpu_hold), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) begin
      wa.push_back(mem_waddr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      in_byte = 8'($urandom);
    end
  endtask

  task automatic do_start(input bit with_valid);
    @(negedge clk);
    start = 1'b1;
    in_valid = with_valid;
    in_byte = 8'h02;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    base = wa.size();
  endtask

  // Holds the byte valid until in_ready is seen, so the next rising edge takes it.
  task automatic send(input logic [7:0] b, input int gap, input bit st);
    int t;
    idle(gap);
    t = 0;
    forever begin
      @(negedge clk);
      start = st;
      in_valid = 1'b1;
      in_byte = b;
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_stream(input logic [7:0] cks, input bit gaps);
    logic [7:0] s[6];
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, cks};
    for (int i = 0; i < 6; i++) begin
      if (gaps) send(s[i], int'($urandom_range(0, 3)), (i == 2 || i == 4));
      else      send(s[i], 0, 1'b0);
    end
    idle(3);
  endtask

  task automatic chk_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wa.size() - base), 32'd2);
    if (wa.size() - base == 2) begin
      chk({tag, "_a0"}, 32'(wa[base]), 32'h00);
      chk({tag, "_d0"}, 32'(wd[base]), 32'h1234);
      chk({tag, "_a1"}, 32'(wa[base+1]), 32'h01);
      chk({tag, "_d1"}, 32'(wd[base+1]), 32'hABCD);
    end
    chk({tag, "_wc"}, 32'(word_count), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    idle(2);
    chk("idle_nowrite", 32'(wa.size()), 32'd0);

    // Test 2: good load, start issued together with in_valid
    do_start(1'b1);
    chk("t2_ready_after_start", 32'(in_ready), 32'd1);
    send_stream(8'h42, 1'b0);
    chk_two_writes("t2");
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_error", 32'(error), 32'd0);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    chk("t2_ready", 32'(in_ready), 32'd0);

    // Test 3: bad checksum
    do_start(1'b0);
    chk("t3_hold_restart", 32'(cpu_hold), 32'd1);
    chk("t3_done_cleared", 32'(done), 32'd0);
    send_stream(8'h43, 1'b0);
    chk_two_writes("t3");
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd1);

    // Test 4: gaps and mid-load start pulses
    do_start(1'b0);
    chk("t4_error_cleared", 32'(error), 32'd0);
    send_stream(8'h42, 1'b1);
    chk_two_writes("t4");
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_error", 32'(error), 32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd0);

    // Test 5: empty images
    do_start(1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    idle(3);
    chk("t5_nwr", 32'(wa.size() - base), 32'd0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_wc", 32'(word_count), 32'd0);
    do_start(1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    idle(3);
    chk("t5b_nwr", 32'(wa.size() - base), 32'd0);
    chk("t5b_error", 32'(error), 32'd1);
    chk("t5b_done", 32'(done), 32'd0);
    chk("t5b_hold", 32'(cpu_hold), 32'd1);

    // Test 6: reset right after the first WRITE
    do_start(1'b0);
    send(8'h02, 0, 1'b0);
    send(8'h12, 0, 1'b0);
    send(8'h34, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_write_strobe", 32'(mem_write), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'hAB;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    chk("t6_ready", 32'(in_ready), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_wc", 32'(word_count), 32'd0);
    idle(5);
    chk("t6_nwr", 32'(wa.size() - base), 32'd1);
    chk("t6_write_low", 32'(mem_write), 32'd0);
    if (wa.size() - base >= 1) chk("t6_d0", 32'(wd[base]), 32'h1234);
    do_start(1'b0);
    send_stream(8'h42, 1'b0);
    chk_two_writes("t6r");
    chk("t6r_done", 32'(done), 32'd1);
    chk("t6r_hold", 32'(cpu_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
